// File: rtl/tone_pkg.sv
// Shared types and constants for the tone decoder.
// Holds FSM states, the note event bundle and the silence divisor.
package tone_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TONE    = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] period;
        logic [15:0] ms;
        logic        rest;
    } note_t;

    localparam int unsigned SILENCE_DIV = 50;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for the speaker line with a one-cycle
// rising-edge pulse on the synchronized signal.
module edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic [1:0] sync;
    logic       prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= 2'b00;
            prev <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            prev <= sync[1];
        end
    end

    assign rise = sync[1] & ~prev;

endmodule

// File: rtl/tone_decoder.sv
// Measures the speaker square wave and emits one event per tone or
// rest segment through a single-entry valid/ready output register.
module tone_decoder
    import tone_pkg::*;
#(
    parameter int unsigned FCLK      = 50000000,
    parameter int unsigned TOL_SHIFT = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tone_in,
    output logic        note_valid,
    input  logic        note_ready,
    output logic [31:0] note_period,
    output logic [15:0] note_ms,
    output logic        note_rest,
    output logic        overflow
);

    localparam int unsigned TICK_DIV = FCLK / 1000;
    localparam int unsigned DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
    localparam logic [31:0] TIMEOUT = 32'(FCLK / SILENCE_DIV);

    logic          rise;
    logic [31:0]   cnt;
    logic [DW-1:0] div;
    logic          tick;
    logic [15:0]   seg_ms;
    logic [31:0]   ref_period;
    logic [31:0]   ref_nx;
    logic [31:0]   diff;
    logic          timeout;
    logic          emit;
    logic          seg_clr;
    state_t        state;
    state_t        state_nx;
    note_t         evt;
    note_t         note;

    edge_sync u_edge_sync (
        .clk   (clk),
        .reset (reset),
        .din   (tone_in),
        .rise  (rise)
    );

    assign tick    = (div == DIV_LAST);
    assign timeout = !rise && (cnt == TIMEOUT);
    assign diff    = (cnt > ref_period) ? (cnt - ref_period)
                                        : (ref_period - cnt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= 32'd0;
            div    <= '0;
            seg_ms <= 16'd0;
        end else begin
            if (rise)
                cnt <= 32'd1;
            else if (cnt != 32'hFFFF_FFFF)
                cnt <= cnt + 32'd1;

            if (tick)
                div <= '0;
            else
                div <= div + DW'(1);

            if (seg_clr)
                seg_ms <= 16'd0;
            else if (tick && seg_ms != 16'hFFFF)
                seg_ms <= seg_ms + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            ref_period <= 32'd0;
        end else begin
            state      <= state_nx;
            ref_period <= ref_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ref_nx   = ref_period;
        emit     = 1'b0;
        seg_clr  = 1'b0;
        evt      = '0;
        unique case (state)
            ST_IDLE: begin
                if (rise) begin
                    emit     = (seg_ms != 16'd0);
                    evt.ms   = seg_ms;
                    evt.rest = 1'b1;
                    seg_clr  = 1'b1;
                    state_nx = ST_ACQUIRE;
                end
            end
            ST_ACQUIRE: begin
                // a lone edge that times out merges into the rest
                if (rise) begin
                    ref_nx   = cnt;
                    state_nx = ST_TONE;
                end else if (timeout) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_TONE: begin
                evt.period = ref_period;
                evt.ms     = seg_ms;
                if (rise) begin
                    if (diff > (ref_period >> TOL_SHIFT)) begin
                        emit    = 1'b1;
                        seg_clr = 1'b1;
                        ref_nx  = cnt;
                    end
                end else if (timeout) begin
                    emit     = 1'b1;
                    seg_clr  = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // measurement never waits on the consumer; a full register drops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            note       <= '0;
            note_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (emit) begin
                if (!note_valid || note_ready) begin
                    note       <= evt;
                    note_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (note_valid && note_ready) begin
                note_valid <= 1'b0;
            end
        end
    end

    assign note_period = note.period;
    assign note_ms     = note.ms;
    assign note_rest   = note.rest;

endmodule

// File: tb/tb_tone_decoder.sv
// Bench for tone_decoder: directed tone/rest scenarios and a random
// segment sequence checked against an edge-list model.
`timescale 1ns/1ps
module tb_tone_decoder;

    localparam int FCLK  = 100000;
    localparam int MS    = FCLK / 1000;
    localparam int TMO   = FCLK / 50;
    localparam int P500  = FCLK / 500;
    localparam int P1000 = FCLK / 1000;
    localparam int TOLS  = 5;
    localparam int TAIL  = 21 * MS;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tone_in = 1'b0;
    logic        note_ready = 1'b1;
    logic        note_valid;
    logic [31:0] note_period;
    logic [15:0] note_ms;
    logic        note_rest;
    logic        overflow;

    typedef struct {
        int period;
        int ms;
        int rest;
    } ev_t;

    typedef struct {
        int period;
        int span;
        int rest;
    } xev_t;

    ev_t   got[$];
    xev_t  exp_q[$];
    int    edges[$];
    int    cyc = 0;
    int    t_seg0 = 0;
    int    checks = 0;
    int    failures = 0;
    bit    ready_val = 1'b1;
    bit    rnd_ready = 1'b0;
    bit    hold_watch = 1'b0;
    int    hold_bad = 0;
    logic [49:0] snap;

    tone_decoder #(
        .FCLK      (FCLK),
        .TOL_SHIFT (TOLS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tone_in     (tone_in),
        .note_valid  (note_valid),
        .note_ready  (note_ready),
        .note_period (note_period),
        .note_ms     (note_ms),
        .note_rest   (note_rest),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        note_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_val;
    end

    always @(negedge clk) begin
        if (!reset && note_valid && note_ready)
            got.push_back('{int'(note_period), int'(note_ms), int'(note_rest)});
        if (hold_watch &&
            {note_valid, note_period, note_ms, note_rest} !== snap)
            hold_bad++;
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tone_in = 1'b0;
        step(3);
        reset = 1'b0;
        t_seg0 = cyc;
        got.delete();
        edges.delete();
        step(1);
    endtask

    task automatic tone_edges(int per, int n);
        for (int i = 0; i < n; i++) begin
            tone_in = 1'b1;
            edges.push_back(cyc);
            step(per / 2);
            tone_in = 1'b0;
            step(per - per / 2);
        end
    endtask

    // segment rules applied to the list of driven rising-edge times
    task automatic run_model(int t_end);
        int st, seg, prev, rp, t, d;
        st = 0;
        seg = t_seg0;
        prev = 0;
        rp = 0;
        exp_q.delete();
        for (int i = 0; i <= edges.size(); i++) begin
            t = (i < edges.size()) ? edges[i] : t_end;
            if (st != 0 && t - prev > TMO) begin
                if (st == 2) begin
                    exp_q.push_back('{rp, prev + TMO - seg, 0});
                    seg = prev + TMO;
                end
                st = 0;
            end
            if (i == edges.size()) break;
            if (st == 0) begin
                if (t - seg >= MS) exp_q.push_back('{0, t - seg, 1});
                seg = t;
                st = 1;
            end else if (st == 1) begin
                rp = t - prev;
                st = 2;
            end else begin
                d = t - prev - rp;
                if (d < 0) d = -d;
                if (d > (rp >> TOLS)) begin
                    exp_q.push_back('{rp, t - seg, 0});
                    rp = t - prev;
                    seg = t;
                end
            end
            prev = t;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(2);
        checks++;
        if ({note_valid, note_period, note_ms, note_rest, overflow} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%0d period=%0d ms=%0d rest=%0d ovf=%0d, want all 0",
                     note_valid, note_period, note_ms, note_rest, overflow);
        end
        do_reset();
        step(50);
        checks++;
        if (note_valid !== 1'b0 || got.size() != 0) begin
            failures++;
            $display("FAIL reset_quiet: valid=%0d events=%0d, want 0 and 0",
                     note_valid, got.size());
        end
    endtask

    task automatic test_basic();
        do_reset();
        step(10 * MS);
        tone_edges(P500, 51);
        step(TAIL);
        checks++;
        if (got.size() != 2) begin
            failures++;
            $display("FAIL basic_count: got %0d events, want 2", got.size());
        end
        if (got.size() == 2) begin
            checks++;
            if (got[0].rest != 1 || got[0].period != 0 ||
                got[0].ms < 9 || got[0].ms > 11) begin
                failures++;
                $display("FAIL basic_rest: period=%0d ms=%0d rest=%0d, want 0 9..11 1",
                         got[0].period, got[0].ms, got[0].rest);
            end
            checks++;
            if (got[1].rest != 0 || got[1].period != P500 ||
                got[1].ms < 119 || got[1].ms > 121) begin
                failures++;
                $display("FAIL basic_tone: period=%0d ms=%0d rest=%0d, want %0d 119..121 0",
                         got[1].period, got[1].ms, got[1].rest, P500);
            end
        end
    endtask

    task automatic test_switch();
        do_reset();
        step(5 * MS);
        tone_edges(P500, 25);
        tone_edges(P1000, 50);
        step(TAIL);
        checks++;
        if (got.size() != 3) begin
            failures++;
            $display("FAIL switch_count: got %0d events, want 3", got.size());
        end
        if (got.size() == 3) begin
            checks++;
            if (got[1].rest != 0 || got[1].period != P500 ||
                got[1].ms < 49 || got[1].ms > 51) begin
                failures++;
                $display("FAIL switch_first: period=%0d ms=%0d rest=%0d, want %0d 49..51 0",
                         got[1].period, got[1].ms, got[1].rest, P500);
            end
            checks++;
            if (got[2].rest != 0 || got[2].period != P1000) begin
                failures++;
                $display("FAIL switch_second: period=%0d rest=%0d, want %0d 0",
                         got[2].period, got[2].rest, P1000);
            end
        end
    endtask

    task automatic test_jitter();
        int ntone;
        int per;
        do_reset();
        step(5 * MS);
        for (int i = 0; i < 30; i++)
            tone_edges((i % 2 != 0) ? P500 + P500 * 15 / 1000 : P500, 1);
        tone_edges(P500, 1);
        step(TAIL);
        ntone = 0;
        per = -1;
        foreach (got[i]) begin
            if (got[i].rest == 0) begin
                ntone++;
                per = got[i].period;
            end
        end
        checks++;
        if (ntone != 1 || per != P500) begin
            failures++;
            $display("FAIL jitter_tone: tone events=%0d period=%0d, want 1 %0d",
                     ntone, per, P500);
        end
    endtask

    task automatic test_backpressure();
        ready_val = 1'b0;
        step(2);
        do_reset();
        hold_bad = 0;
        hold_watch = 1'b0;
        snap = '0;
        fork
            begin
                step(10 * MS);
                tone_edges(P500, 10);
                step(TAIL);
            end
            begin
                for (int i = 0; i < 20 * MS && note_valid !== 1'b1; i++)
                    step(1);
                snap = {note_valid, note_period, note_ms, note_rest};
                hold_watch = 1'b1;
            end
        join
        hold_watch = 1'b0;
        checks++;
        if (note_valid !== 1'b1 || note_rest !== 1'b1 || note_period !== 32'd0 ||
            note_ms < 16'd9 || note_ms > 16'd11) begin
            failures++;
            $display("FAIL bp_held: valid=%0d period=%0d ms=%0d rest=%0d, want 1 0 9..11 1",
                     note_valid, note_period, note_ms, note_rest);
        end
        checks++;
        if (hold_bad != 0) begin
            failures++;
            $display("FAIL bp_stable: %0d cycles changed while held, want 0", hold_bad);
        end
        checks++;
        if (overflow !== 1'b1 || got.size() != 0) begin
            failures++;
            $display("FAIL bp_overflow: overflow=%0d accepted=%0d, want 1 0",
                     overflow, got.size());
        end
        ready_val = 1'b1;
        step(3);
        checks++;
        if (note_valid !== 1'b0 || got.size() != 1 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL bp_drain: valid=%0d accepted=%0d overflow=%0d, want 0 1 1",
                     note_valid, got.size(), overflow);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        step(20);
        tone_in = 1'b1;
        step(50);
        tone_in = 1'b0;
        step(30 * MS);
        tone_edges(P500, 10);
        step(TAIL);
        checks++;
        if (got.size() != 2) begin
            failures++;
            $display("FAIL glitch_count: got %0d events, want 2", got.size());
        end
        if (got.size() == 2) begin
            checks++;
            if (got[0].rest != 1 || got[0].ms < 29 || got[0].ms > 31) begin
                failures++;
                $display("FAIL glitch_rest: ms=%0d rest=%0d, want 29..31 1",
                         got[0].ms, got[0].rest);
            end
            checks++;
            if (got[1].rest != 0 || got[1].period != P500) begin
                failures++;
                $display("FAIL glitch_tone: period=%0d rest=%0d, want %0d 0",
                         got[1].period, got[1].rest, P500);
            end
        end
    endtask

    task automatic test_reset_mid();
        ready_val = 1'b0;
        step(2);
        do_reset();
        step(5 * MS);
        tone_edges(P500, 8);
        checks++;
        if (note_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_held: valid=%0d, want 1", note_valid);
        end
        reset = 1'b1;
        tone_in = 1'b0;
        #1;
        checks++;
        if ({note_valid, note_period, note_ms, note_rest, overflow} !== '0) begin
            failures++;
            $display("FAIL rst_async: valid=%0d period=%0d ms=%0d rest=%0d ovf=%0d, want all 0",
                     note_valid, note_period, note_ms, note_rest, overflow);
        end
        step(3);
        reset = 1'b0;
        t_seg0 = cyc;
        got.delete();
        edges.delete();
        ready_val = 1'b1;
        step(TAIL + 5 * MS);
        checks++;
        if (got.size() != 0 || note_valid !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL rst_no_event: events=%0d valid=%0d ovf=%0d, want 0 0 0",
                     got.size(), note_valid, overflow);
        end
    endtask

    task automatic test_random();
        int gap, p1, p2, n1, n2, lo, hi;
        rnd_ready = 1'b1;
        do_reset();
        for (int s = 0; s < 3; s++) begin
            gap = ($urandom_range(0, 1) != 0) ? $urandom_range(5, 15)
                                              : $urandom_range(25, 35);
            p1 = $urandom_range(100, 250);
            p2 = ($urandom_range(0, 1) != 0) ? p1 * 3 / 2 : p1 * 2 / 3;
            n1 = $urandom_range(3, 5);
            n2 = $urandom_range(0, 1) * $urandom_range(3, 5);
            step(gap * MS);
            tone_edges(p1, n1);
            if (n2 != 0) tone_edges(p2, n2);
        end
        step(TAIL);
        run_model(cyc);
        rnd_ready = 1'b0;
        step(2);
        checks++;
        if (got.size() != exp_q.size()) begin
            failures++;
            $display("FAIL rand_count: got %0d events, want %0d",
                     got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            lo = exp_q[i].span / MS - 1;
            hi = exp_q[i].span / MS + 1;
            checks++;
            if (got[i].period != exp_q[i].period || got[i].rest != exp_q[i].rest ||
                got[i].ms < lo || got[i].ms > hi) begin
                failures++;
                $display("FAIL rand_event%0d: period=%0d ms=%0d rest=%0d, want %0d %0d..%0d %0d",
                         i, got[i].period, got[i].ms, got[i].rest,
                         exp_q[i].period, lo, hi, exp_q[i].rest);
            end
        end
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL rand_overflow: overflow=%0d, want 0", overflow);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_switch();
        test_jitter();
        test_backpressure();
        test_glitch();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
